branch_logic: RTL and testbench

- Branch-condition evaluator for the KGP-RISC datapath; sits between the ALU flag outputs and the PC-select mux.
- Decodes the 3-bit branch-type field against the carry flag and the 2-bit sign/zero flags.
- Produces a combinational take-branch decision plus a registered copy for the pipelined PC update.

---
 rtl/branch_logic_if.sv | 19 +
 rtl/branch_logic.sv | 51 +++++
 tb/tb_branch_logic.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/branch_logic_if.sv
// Flag/decode bundle between the decoder/ALU side and the branch evaluator.
interface branch_logic_if;
  logic [2:0] x;
  logic       carry;
  logic [1:0] sign;
  logic       valid;
  logic       branch;
  logic       branch_q;

  modport master (
    output x, carry, sign, valid,
    input  branch, branch_q
  );

  modport slave (
    input  x, carry, sign, valid,
    output branch, branch_q
  );
endinterface

// File: rtl/branch_logic.sv
// KGP-RISC branch-condition evaluator: decodes the branch type against ALU flags,
// giving a combinational take decision and a valid-qualified registered copy.
module branch_logic (
  input  logic           clk,
  input  logic           rst_n,
  branch_logic_if.slave  bus
);

  // sign[1] = negative, sign[0] = zero; each flag is used on its own even if both are set.
  // Any undefined code (including X/Z) falls to the default and never takes the branch.
  function automatic logic decode_branch(
    input logic [2:0] code,
    input logic       cy,
    input logic [1:0] flg
  );
    logic taken;
    taken = 1'b0;
    case (code)
      3'b000:  taken = 1'b0;
      3'b001:  taken = cy;
      3'b010:  taken = ~cy;
      3'b011:  taken = flg[0];
      3'b100:  taken = flg[1];
      3'b101:  taken = ~flg[0];
      3'b110:  taken = 1'b1;
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  logic w_branch_p0;
  logic w_vld_p0;
  logic r_branch_p1;

  assign w_branch_p0 = decode_branch(bus.x, bus.carry, bus.sign);
  assign w_vld_p0    = bus.valid;
  assign bus.branch  = w_branch_p0;

  // p0 -> p1: valid folds into the registered decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_p1 <= 1'b0;
    end else begin
      r_branch_p1 <= w_vld_p0 & w_branch_p0;
    end
  end

  assign bus.branch_q = r_branch_p1;

endmodule

// File: tb/tb_branch_logic.sv
// Directed and exhaustive checks for branch_logic's combinational and registered outputs.
module tb_branch_logic;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  branch_logic_if bus ();

  branch_logic dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] x;
    logic       carry;
    logic [1:0] sign;
    logic       exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] x, input logic c, input logic [1:0] s, input logic v);
    bus.x     = x;
    bus.carry = c;
    bus.sign  = s;
    bus.valid = v;
  endtask

  // Truth table per code, built from the instruction definitions, indexed by x.
  function automatic logic ref_branch(input logic [2:0] x, input logic c, input logic [1:0] s);
    logic [7:0] tbl;
    tbl = {1'b1, 1'b1, ~s[0], s[1], s[0], ~c, c, 1'b0};
    return tbl[x];
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0]  = '{"bcy_c1",        3'b001, 1'b1, 2'b00, 1'b1};
    vecs[1]  = '{"bncy_c0",       3'b010, 1'b0, 2'b00, 1'b1};
    vecs[2]  = '{"bcy_c0",        3'b001, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{"bz_z1",         3'b011, 1'b0, 2'b01, 1'b1};
    vecs[4]  = '{"bz_neg_only",   3'b011, 1'b0, 2'b10, 1'b0};
    vecs[5]  = '{"bnz_z0",        3'b101, 1'b0, 2'b00, 1'b1};
    vecs[6]  = '{"bnz_z1",        3'b101, 1'b0, 2'b01, 1'b0};
    vecs[7]  = '{"bltz_n1",       3'b100, 1'b0, 2'b10, 1'b1};
    vecs[8]  = '{"bltz_n0",       3'b100, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{"br_flags0",     3'b110, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{"bl_flags0",     3'b111, 1'b0, 2'b00, 1'b1};
    vecs[11] = '{"nop_flags1",    3'b000, 1'b1, 2'b11, 1'b0};
    vecs[12] = '{"bz_s11_c1",     3'b011, 1'b1, 2'b11, 1'b1};
    vecs[13] = '{"bcy_s11",       3'b001, 1'b1, 2'b11, 1'b1};
    vecs[14] = '{"bnz_s11",       3'b101, 1'b1, 2'b11, 1'b0};
    vecs[15] = '{"bltz_s11_c0",   3'b100, 1'b0, 2'b11, 1'b1};
    vecs[16] = '{"bncy_c1_s11",   3'b010, 1'b1, 2'b11, 1'b0};

    // Reset state: decode says take, but flop is held clear
    rst_n = 1'b0;
    drive(3'b110, 1'b0, 2'b00, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_branch_q", bus.branch_q, 1'b0);
    check("reset_branch_comb", bus.branch, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;

    // Combinational table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].x, vecs[i].carry, vecs[i].sign, 1'b0);
      #1;
      check(vecs[i].name, bus.branch, vecs[i].exp);
    end
    @(posedge clk); #1;
    check("valid0_q_low", bus.branch_q, 1'b0);

    // Registered path: rises only after the edge
    @(negedge clk);
    drive(3'b110, 1'b0, 2'b00, 1'b1);
    #1;
    check("q_before_edge", bus.branch_q, 1'b0);
    @(posedge clk); #1;
    check("q_after_edge", bus.branch_q, 1'b1);
    @(negedge clk);
    bus.valid = 1'b0;
    @(posedge clk); #1;
    check("q_valid0", bus.branch_q, 1'b0);
    check("comb_valid0", bus.branch, 1'b1);

    // Async reset mid-operation
    @(negedge clk);
    bus.valid = 1'b1;
    @(posedge clk); #1;
    check("q_set_again", bus.branch_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_q", bus.branch_q, 1'b0);
    check("comb_in_reset", bus.branch, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("q_after_release_noedge", bus.branch_q, 1'b0);
    @(posedge clk); #1;
    check("q_first_edge_after_reset", bus.branch_q, 1'b1);

    // Undefined opcode never branches
    @(negedge clk);
    drive(3'bxxx, 1'b1, 2'b11, 1'b1);
    #1;
    check("x_opcode", bus.branch, 1'b0);

    // Exhaustive sweep, registered copy checked one cycle later
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      logic       e;
      v = i[5:0];
      e = ref_branch(v[5:3], v[2], v[1:0]);
      @(negedge clk);
      drive(v[5:3], v[2], v[1:0], 1'b1);
      #1;
      check($sformatf("sweep_comb_%0d", i), bus.branch, e);
      @(posedge clk); #1;
      check($sformatf("sweep_q_%0d", i), bus.branch_q, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
